ff_reg_bank: RTL
================

# ff_reg_bank

Parametrised register bank built from synchronous flip-flop storage. It holds DEPTH words of WIDTH bits and provides one masked write port and two registered read ports. Each read port also outputs the complement of its data. Per-entry valid bits and an occupancy count sit alongside the storage. This block is the next-generation storage element in the Memory area, replacing single-bit flip-flop instances wherever an addressed, multi-bit store is needed.

## Interface
- WIDTH, 8, data bits per entry (>=1)
- DEPTH, 8, number of entries (>=2; need not be a power of two)
- AW, $clog2(DEPTH), address width
- BYPASS, 1, 1 = same-cycle write forwards to a read of the same address; 0 = the read returns the pre-write contents
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every entry and every read data register on reset/clear
- Clk  in  1  clock; all state updates on the rising edge
- R  in  1  synchronous, active-high reset
- Clr  in  1  synchronous clear of all entries (same effect as R on storage, valid bits and count)
- WrEn  in  1  write strobe
- WrAddr  in  AW  write address
- WrData  in  WIDTH  write data
- WrMask  in  WIDTH  per-bit write enable; 1 = take the WrData bit, 0 = keep the stored bit
- RdEnA / RdEnB  in  1  read strobe, port A / B
- RdAddrA / RdAddrB  in  AW  read address
- RdDataA / RdDataB  out  WIDTH  registered read data
- RdDataAn / RdDataBn  out  WIDTH  bitwise complement of RdDataA / RdDataB, always consistent with them
- RdValidA / RdValidB  out  1  the entry read had been written since the last reset/clear
- ValidCount  out  AW+1  number of entries with valid=1

## Operation
- Priority per edge: R > Clr > WrEn. R and Clr both do the following:
  - every entry becomes RESET_VAL and every valid bit becomes 0;
  - ValidCount becomes 0;
  - RdData* become RESET_VAL, RdData*n become ~RESET_VAL, RdValid* become 0, regardless of RdEn*.
- Write: when WrEn=1, WrAddr<DEPTH and no R/Clr:
  - mem[WrAddr] <= (mem & ~WrMask) | (WrData & WrMask);
  - valid[WrAddr] <= 1, even when WrMask=0.
- ValidCount increments by 1 only when a write sets a previously clear valid bit. It never exceeds DEPTH and never decrements except on R/Clr.
- Out-of-range write (WrAddr>=DEPTH): no storage, valid or count change.
- Read: when RdEnX=1, RdDataX and RdValidX load from entry RdAddrX.
  - RdAddrX>=DEPTH loads RESET_VAL and valid 0.
  - RdEnX=0 holds the previous RdDataX/RdValidX.
- Same-address write and read in one cycle:
  - BYPASS=1: the read loads the post-mask merged value, with valid=1.
  - BYPASS=0: the read loads the old value and old valid bit.
- Both read ports are independent and may address the same entry in the same cycle.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible to a read issued at edge N+1 on RdData at N+1 when BYPASS=0, or at N when BYPASS=1 and the addresses match.
- Read latency: 1 cycle from RdEn sample to RdData/RdValid.
- ValidCount updates on the same edge as the write that sets the valid bit.
- R or Clr asserted mid-operation takes effect at that edge, and any write in that cycle is discarded. The first cycle after R/Clr deasserts accepts writes normally.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold R=1 for 2 cycles with random WrEn/RdEn -> RdDataA=RdDataB=0x00, RdDataAn=0xFF, RdValid*=0, ValidCount=0; a read of addr 3 afterwards returns 0x00 with valid 0.
- Write/read: write 0xA5 to addr 2 (mask 0xFF), then read A@2 and B@2 -> both return 0xA5, An=0x5A, valid 1, ValidCount=1.
- Masked write: addr 2 holds 0xA5; write 0x0F with mask 0xF0 -> the next read returns 0x05. Rewriting addr 2 leaves ValidCount at 1.
- Bypass: write 0x3C to addr 5 while RdEnA@5 in the same cycle -> RdDataA=0x3C when BYPASS=1; RESET_VAL with valid 0 when BYPASS=0.
- Full/range: with DEPTH=6, write all addrs 0..5 then addr 7 -> ValidCount=6, no change from the addr-7 write; a read @7 returns RESET_VAL with valid 0.
- Clear vs write: Clr=1 and WrEn=1 (addr 1, 0x77) on the same edge -> all entries RESET_VAL, ValidCount=0; a read @1 returns RESET_VAL with valid 0.

Source files
------------

// File: rtl/ff_reg_bank.sv
// Addressed flip-flop register bank: one masked write port, two registered
// read ports with complemented data, per-entry valid bits and an occupancy count.
module ff_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 8,
  parameter int unsigned      AW        = $clog2(DEPTH),
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             Clr,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] WrMask,
  input  logic             RdEnA,
  input  logic [AW-1:0]    RdAddrA,
  input  logic             RdEnB,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataA,
  output logic [WIDTH-1:0] RdDataAn,
  output logic             RdValidA,
  output logic [WIDTH-1:0] RdDataB,
  output logic [WIDTH-1:0] RdDataBn,
  output logic             RdValidB,
  output logic [AW:0]      ValidCount
);

  // Depth at address width + 1 so non-power-of-two depths compare cleanly
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_hit_c;
  logic             wr_new_entry_c;
  logic [WIDTH-1:0] wr_old_c;
  logic [WIDTH-1:0] wr_merged_c;
  logic [WIDTH-1:0] rd_data_a_c;
  logic             rd_valid_a_c;
  logic [WIDTH-1:0] rd_data_b_c;
  logic             rd_valid_b_c;

  // Write decode: in-range check, bit-masked merge and first-write detection
  always_comb begin
    wr_hit_c       = WrEn && ({1'b0, WrAddr} < DEPTH_W);
    wr_old_c       = RESET_VAL;
    wr_new_entry_c = 1'b0;
    if (wr_hit_c) begin
      wr_old_c       = mem[WrAddr];
      wr_new_entry_c = !valid[WrAddr];
    end
    wr_merged_c = (wr_old_c & ~WrMask) | (WrData & WrMask);
  end

  // Port A lookup; out-of-range reads return the reset value as invalid
  always_comb begin
    rd_data_a_c  = RESET_VAL;
    rd_valid_a_c = 1'b0;
    if ({1'b0, RdAddrA} < DEPTH_W) begin
      if (BYPASS && wr_hit_c && (RdAddrA == WrAddr)) begin
        rd_data_a_c  = wr_merged_c;
        rd_valid_a_c = 1'b1;
      end else begin
        rd_data_a_c  = mem[RdAddrA];
        rd_valid_a_c = valid[RdAddrA];
      end
    end
  end

  // Port B lookup; identical to port A and fully independent of it
  always_comb begin
    rd_data_b_c  = RESET_VAL;
    rd_valid_b_c = 1'b0;
    if ({1'b0, RdAddrB} < DEPTH_W) begin
      if (BYPASS && wr_hit_c && (RdAddrB == WrAddr)) begin
        rd_data_b_c  = wr_merged_c;
        rd_valid_b_c = 1'b1;
      end else begin
        rd_data_b_c  = mem[RdAddrB];
        rd_valid_b_c = valid[RdAddrB];
      end
    end
  end

  // Storage, valid bits and occupancy; reset/clear discards any same-cycle write
  always_ff @(posedge Clk) begin
    if (R || Clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= RESET_VAL;
      end
      valid      <= '0;
      ValidCount <= '0;
    end else if (wr_hit_c) begin
      mem[WrAddr]   <= wr_merged_c;
      valid[WrAddr] <= 1'b1;
      if (wr_new_entry_c) begin
        ValidCount <= ValidCount + (AW+1)'(1);
      end
    end
  end

  // Read data registers; complement is loaded alongside so both always agree
  always_ff @(posedge Clk) begin
    if (R || Clr) begin
      RdDataA  <= RESET_VAL;
      RdDataAn <= ~RESET_VAL;
      RdValidA <= 1'b0;
      RdDataB  <= RESET_VAL;
      RdDataBn <= ~RESET_VAL;
      RdValidB <= 1'b0;
    end else begin
      if (RdEnA) begin
        RdDataA  <= rd_data_a_c;
        RdDataAn <= ~rd_data_a_c;
        RdValidA <= rd_valid_a_c;
      end
      if (RdEnB) begin
        RdDataB  <= rd_data_b_c;
        RdDataBn <= ~rd_data_b_c;
        RdValidB <= rd_valid_b_c;
      end
    end
  end

endmodule
